// File: rtl/seq_pkg.sv
// Shared definitions for the contador sequence checker: the legal count order,
// checker states and lookup helpers.
package seq_pkg;

  localparam logic [3:0] START = 4'd6;

  // Count order of contador; the index is the checker's notion of position.
  localparam logic [3:0] SEQ [0:7] = '{4'd6, 4'd5, 4'd13, 4'd2, 4'd4, 4'd11, 4'd9, 4'd8};

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } seq_idx_t;

  // Map a code to its position in the sequence; valid=0 for illegal codes.
  function automatic seq_idx_t seq_index(input logic [3:0] value);
    seq_idx_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (SEQ[i] == value) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

  // Code expected after position idx; the 3-bit add wraps 7 back to 0.
  function automatic logic [3:0] seq_next(input logic [2:0] idx);
    logic [2:0] n;
    n = idx + 3'd1;
    return SEQ[n];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         C,
  input  logic         nR,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Increment on request unless already saturated.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_checker.sv
// Monitors contador's output, locks onto its count order and flags
// out-of-order or illegal codes, counting laps and errors.
module seq_checker
  import seq_pkg::*;
#(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LAP_W  = 8,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             C,
  input  logic             nR,
  input  logic             en,
  input  logic [3:0]       Q,
  output logic             locked,
  output logic [2:0]       pos,
  output logic             lap,
  output logic             err,
  output logic             illegal,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] LockN = 4'(LOCK_N);

  state_e     state_q;
  logic [2:0] pos_q;
  logic [3:0] match_q;
  logic       locked_q, lap_q, err_q, illegal_q;

  seq_idx_t   q_idx;
  logic [3:0] nxt;
  logic       in_order, lap_hit, err_hit;

  // Decode the current sample against the expected next code.
  always_comb begin
    q_idx    = seq_index(Q);
    nxt      = seq_next(pos_q);
    in_order = (Q == nxt);
    lap_hit  = en && (state_q == LOCKED) && in_order && (pos_q == 3'd7);
    err_hit  = en && (state_q == LOCKED) && !in_order;
  end

  // Checker FSM with registered status and pulse outputs.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q   <= SEARCH;
      pos_q     <= 3'd0;
      match_q   <= 4'd0;
      locked_q  <= 1'b0;
      lap_q     <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      lap_q     <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      if (en) begin
        illegal_q <= !q_idx.valid;
        unique case (state_q)
          SEARCH: begin
            if (Q == START) begin
              pos_q   <= 3'd0;
              match_q <= 4'd1;
              if (LOCK_N == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q <= ACQUIRE;
              end
            end
          end
          ACQUIRE: begin
            if (in_order) begin
              pos_q <= pos_q + 3'd1;
              if (match_q + 4'd1 >= LockN) begin
                match_q  <= LockN;
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                match_q <= match_q + 4'd1;
              end
            end else if (Q == START) begin
              pos_q   <= 3'd0;
              match_q <= 4'd1;
            end else begin
              state_q <= SEARCH;
              match_q <= 4'd0;
            end
          end
          LOCKED: begin
            if (err_hit) begin
              err_q <= 1'b1;
              if (Q == START) begin
                // A stray 6 is treated as a fresh start of the sequence.
                pos_q   <= 3'd0;
                match_q <= 4'd1;
                if (LOCK_N != 1) begin
                  state_q  <= ACQUIRE;
                  locked_q <= 1'b0;
                end
              end else begin
                state_q  <= SEARCH;
                match_q  <= 4'd0;
                locked_q <= 1'b0;
              end
            end else begin
              pos_q <= pos_q + 3'd1;
              lap_q <= lap_hit;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  // Counters advance on the same edge that raises the matching pulse.
  sat_counter #(.W(LAP_W)) u_lap_cnt (
    .C   (C),
    .nR  (nR),
    .inc (lap_hit),
    .cnt (lap_cnt)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .C   (C),
    .nR  (nR),
    .inc (err_hit),
    .cnt (err_cnt)
  );

  assign locked  = locked_q;
  assign pos     = pos_q;
  assign lap     = lap_q;
  assign err     = err_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: default build, a LOCK_N=1 build and a
// narrow error-counter build, each with its own sample input.
module tb_seq_checker;

  logic       C, nR, en;
  logic [3:0] q0, q1, q2;

  logic       locked0, lap0, err0, ill0;
  logic [2:0] pos0;
  logic [7:0] lapc0, errc0;

  logic       locked1, lap1, err1, ill1;
  logic [2:0] pos1;
  logic [7:0] lapc1, errc1;

  logic       locked2, lap2, err2, ill2;
  logic [2:0] pos2;
  logic [7:0] lapc2;
  logic [1:0] errc2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] seq_tbl [0:7];

  seq_checker #(.LOCK_N(4), .LAP_W(8), .ERR_W(8)) dut (
    .C(C), .nR(nR), .en(en), .Q(q0), .locked(locked0), .pos(pos0), .lap(lap0),
    .err(err0), .illegal(ill0), .lap_cnt(lapc0), .err_cnt(errc0)
  );

  seq_checker #(.LOCK_N(1), .LAP_W(8), .ERR_W(8)) dut1 (
    .C(C), .nR(nR), .en(en), .Q(q1), .locked(locked1), .pos(pos1), .lap(lap1),
    .err(err1), .illegal(ill1), .lap_cnt(lapc1), .err_cnt(errc1)
  );

  seq_checker #(.LOCK_N(4), .LAP_W(8), .ERR_W(2)) dut2 (
    .C(C), .nR(nR), .en(en), .Q(q2), .locked(locked2), .pos(pos2), .lap(lap2),
    .err(err2), .illegal(ill2), .lap_cnt(lapc2), .err_cnt(errc2)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit past the rising edge.
  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic feed0(input logic [3:0] v);
    q0 = v;
    step();
  endtask

  initial begin
    seq_tbl = '{4'd6, 4'd5, 4'd13, 4'd2, 4'd4, 4'd11, 4'd9, 4'd8};
    nR = 1'b0; en = 1'b1; q0 = 4'd0; q1 = 4'd0; q2 = 4'd0;

    // Reset state
    #12;
    check("rst_locked", locked0, 0);
    check("rst_pos", pos0, 0);
    check("rst_pulses", {lap0, err0, ill0}, 0);
    check("rst_lapcnt", lapc0, 0);
    check("rst_errcnt", errc0, 0);
    nR = 1'b1;

    // Lock and laps
    feed0(4'd6);  check("acq6_locked", locked0, 0); check("acq6_pos", pos0, 0);
    feed0(4'd5);  check("acq5_pos", pos0, 1);
    feed0(4'd13); check("acq13_locked", locked0, 0);
    feed0(4'd2);  check("lock_locked", locked0, 1); check("lock_pos", pos0, 3);
    check("lock_lap", lap0, 0);
    for (int k = 0; k < 24; k++) begin
      feed0(seq_tbl[(4 + k) % 8]);
      check("run_lap", lap0, (((4 + k) % 8) == 0) ? 1 : 0);
      check("run_err", {err0, ill0}, 0);
    end
    check("run_lapcnt", lapc0, 3);
    check("run_errcnt", errc0, 0);
    check("run_pos", pos0, 3);
    check("run_locked", locked0, 1);

    // Illegal code while locked at pos=3
    feed0(4'd7);
    check("ill_illegal", ill0, 1); check("ill_err", err0, 1);
    check("ill_errcnt", errc0, 1); check("ill_locked", locked0, 0);
    check("ill_pos_hold", pos0, 3);
    feed0(4'd6);  check("ill_re6_err", err0, 0); check("ill_re6_pos", pos0, 0);
    feed0(4'd5);  check("ill_re5_locked", locked0, 0);
    feed0(4'd13); check("ill_re13_locked", locked0, 0);
    feed0(4'd2);  check("ill_relock", locked0, 1);

    // Skipped value: 2 then 11
    feed0(4'd11);
    check("skip_err", err0, 1); check("skip_illegal", ill0, 0);
    check("skip_locked", locked0, 0); check("skip_errcnt", errc0, 2);
    check("skip_lapcnt", lapc0, 3);
    feed0(4'd6); feed0(4'd5); feed0(4'd13); feed0(4'd2);
    check("skip_relock", locked0, 1);

    // Mismatch equal to 6 at pos=5
    feed0(4'd4); feed0(4'd11);
    check("m6_pre_pos", pos0, 5);
    feed0(4'd6);
    check("m6_err", err0, 1); check("m6_locked", locked0, 0);
    check("m6_pos", pos0, 0); check("m6_errcnt", errc0, 3); check("m6_lap", lap0, 0);
    feed0(4'd5); feed0(4'd13); feed0(4'd2);
    check("m6_relock", locked0, 1); check("m6_relock_pos", pos0, 3);

    // Enable low mid-lap
    feed0(4'd4);
    check("en_pre_pos", pos0, 4);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      feed0(4'd8);
      check("en_pos", pos0, 4);
      check("en_pulses", {lap0, err0, ill0}, 0);
      check("en_cnts", {lapc0, errc0}, {8'd3, 8'd3});
      check("en_locked", locked0, 1);
    end
    en = 1'b1;
    feed0(4'd11);
    check("en_resume_pos", pos0, 5); check("en_resume_err", err0, 0);

    // Asynchronous reset between edges
    #3 nR = 1'b0;
    #1;
    check("arst_locked", locked0, 0); check("arst_pos", pos0, 0);
    check("arst_lapcnt", lapc0, 0); check("arst_errcnt", errc0, 0);
    #2 nR = 1'b1;
    feed0(4'd5);
    check("arst_search_locked", locked0, 0); check("arst_search_pos", pos0, 0);
    check("arst_search_err", err0, 0);

    // LOCK_N=1 instance
    q1 = 4'd6; step();
    check("l1_locked", locked1, 1); check("l1_pos", pos1, 0);
    q1 = 4'd5; step(); q1 = 4'd13; step(); q1 = 4'd2; step();
    q1 = 4'd4; step(); q1 = 4'd11; step();
    check("l1_pos5", pos1, 5);
    q1 = 4'd6; step();
    check("l1_m6_err", err1, 1); check("l1_m6_locked", locked1, 1);
    check("l1_m6_pos", pos1, 0); check("l1_m6_lap", lap1, 0);
    check("l1_m6_errcnt", errc1, 1); check("l1_m6_lapcnt", lapc1, 0);
    q1 = 4'd5; step();
    check("l1_next_pos", pos1, 1); check("l1_next_err", err1, 0);

    // Saturating error counter, ERR_W=2
    for (int e = 0; e < 5; e++) begin
      q2 = 4'd6; step(); q2 = 4'd5; step(); q2 = 4'd13; step(); q2 = 4'd2; step();
      check("sat_locked", locked2, 1);
      q2 = 4'd7; step();
      check("sat_err", err2, 1);
      check("sat_errcnt", errc2, (e + 1 > 3) ? 3 : e + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Downstream monitor for the team's 4-bit arbitrary-sequence counter `contador`, whose count order is 6-5-13-2-4-11-9-8 and repeats.
- Samples the counter output `Q` on the shared clock and locks onto the sequence.
- Reports out-of-order and illegal codes, and counts completed laps and errors.
- Used in benches and as an on-chip health flag for the counter.

Parameters:
- LOCK_N, 4: consecutive in-order samples, including the start value 6, required to assert `locked`. Legal range 1..8.
- LAP_W, 8: width of `lap_cnt`. Saturating.
- ERR_W, 8: width of `err_cnt`. Saturating.

Ports:
- C  in  1  clock; all state updates on rising edge.
- nR  in  1  reset, asynchronous, active-low.
- en  in  1  sample enable; when 0, all state holds.
- Q  in  4  counter value, connected directly to `contador.Q`.
- locked  out  1  checker is locked to the sequence.
- pos  out  3  sequence index of the last accepted sample (0 = value 6 … 7 = value 8).
- lap  out  1  one-cycle pulse: a lap completed (8 followed by 6 while locked).
- err  out  1  one-cycle pulse: sequence violation while locked.
- illegal  out  1  one-cycle pulse: sampled code is not in the sequence.
- lap_cnt  out  LAP_W  saturating count of lap pulses.
- err_cnt  out  ERR_W  saturating count of err pulses.

Behaviour:
- **Reset** (nR=0, takes effect immediately without a clock): state=SEARCH, pos=0, match_cnt=0, all outputs 0. Reset mid-lap discards all progress.
- **Latency:** all outputs are registered. A value sampled at edge k is reflected in outputs right after edge k. Pulses last exactly one cycle.
- **Sequence:** SEQ[0..7] = 6, 5, 13, 2, 4, 11, 9, 8.
- **Illegal codes:** 0, 1, 3, 7, 10, 12, 14, 15. Define nxt = SEQ[(pos+1) mod 8].
- **Enable:** en=0 means no sampling; state, pos and counters hold; lap, err and illegal are 0.
- **illegal** pulses on any enabled sample of an illegal code, in every state.
- **SEARCH:**
  - Sample==6: pos=0, match_cnt=1. Go to LOCKED if LOCK_N==1 (locked=1 the same edge), else to ACQUIRE.
  - Any other sample: stay in SEARCH; no err.
- **ACQUIRE:**
  - Sample==nxt: pos++, match_cnt++. When match_cnt reaches LOCK_N, go to LOCKED and set locked=1.
  - Sample!=nxt and sample==6: restart ACQUIRE with pos=0, match_cnt=1.
  - Otherwise: go to SEARCH.
  - No err is raised in ACQUIRE.
- **LOCKED:**
  - Sample==nxt: pos = (pos+1) mod 8.
  - On the 7→0 transition: lap=1, lap_cnt++.
  - Sample!=nxt: err=1, err_cnt++, locked=0. If sample==6, go to ACQUIRE (pos=0, match_cnt=1, or stay LOCKED if LOCK_N==1). Otherwise go to SEARCH; pos holds its last value.
  - A mismatch that is also an illegal code raises err and illegal in the same cycle.
- **Laps:** counted only while LOCKED. The lap that first reaches lock does not count retroactively.
- **Saturation:** counters stop at all-ones; further pulses still occur.
- **Width:** match_cnt is 4 bits and saturates at LOCK_N.
- **Free-running counter:** a correct counter never produces illegal or err after lock.

Decomposition:
- Shared package `seq_pkg` holds:
  - the SEQ constant array and START=4'd6;
  - the state enum {SEARCH, ACQUIRE, LOCKED};
  - function `seq_index(value)` → {valid, idx[2:0]};
  - function `seq_next(idx)`.
- Sub-module `sat_counter` (param W; ports C, nR, inc, cnt) with saturating increment. Instantiated twice, for `lap_cnt` and `err_cnt`.

Test Plan:
- **Lock and laps** (LOCK_N=4, contador free-running from 6): locked rises at the edge sampling 2 (4th sample). lap pulses on each 8→6 after lock. After 24 further cycles, lap_cnt=3, err_cnt=0.
- **Illegal code while locked:** force Q=7 at pos=3 → illegal=1 and err=1 in the same cycle, err_cnt=1, locked=0, state SEARCH. Next 6 → ACQUIRE; re-locked 4 samples later.
- **Skipped value:** locked, sample 2 then 11 (4 skipped) → err=1, illegal=0, state SEARCH, lap_cnt unchanged.
- **Mismatch equal to 6:** locked at pos=5 (11), sample 6 → err=1, state ACQUIRE, pos=0. With LOCK_N=1 → stays locked, pos=0, no lap.
- **Enable and reset:** en=0 for 5 cycles mid-lap → pos and counters frozen, no pulses. Then pull nR low between clock edges → all outputs 0 immediately; after release, SEARCH.
- **Saturation:** ERR_W=2, inject 5 errors → err_cnt=3, err still pulses on every error.
